// File: rtl/bomb_scheduler_pkg.sv
// bomb_scheduler_pkg: shared slot/owner encodings and timing defaults for the bomb pool
package bomb_scheduler_pkg;
  localparam int ID_W = 3;
  localparam int FUSE_TICKS_DEF = 120;
  localparam int BLAST_TICKS_DEF = 30;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_FUSE = 2'b01, ST_BLAST = 2'b10} slot_state_e;
  typedef enum logic {OWN_P1 = 1'b0, OWN_P2 = 1'b1} owner_e;
endpackage

// File: rtl/bomb_slot.sv
// bomb_slot: one bomb slot with fuse/blast timer, owner and tile
module bomb_slot
  import bomb_scheduler_pkg::*;
#(
  parameter int FUSE_TICKS = FUSE_TICKS_DEF,
  parameter int BLAST_TICKS = BLAST_TICKS_DEF,
  parameter int COORD_W = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear_i,
  input  logic               load_i,
  input  logic               tick_i,
  input  logic               force_i,
  input  owner_e             owner_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  output slot_state_e        state_o,
  output owner_e             owner_o,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               expire_o,
  output logic               free_o
);
  slot_state_e state_q, state_d;
  owner_e owner_q, owner_d;
  logic [7:0] timer_q, timer_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    timer_d = timer_q;
    x_d = x_q;
    y_d = y_q;
    expire_o = 1'b0;
    free_o = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
      owner_d = OWN_P1;
      timer_d = '0;
      x_d = '0;
      y_d = '0;
    end else if (state_q == ST_IDLE && load_i) begin
      state_d = ST_FUSE;
      owner_d = owner_i;
      timer_d = 8'(FUSE_TICKS);
      x_d = x_i;
      y_d = y_i;
    end else if (state_q == ST_FUSE && (force_i || (tick_i && timer_q == 8'd1))) begin
      state_d = ST_BLAST;
      timer_d = 8'(BLAST_TICKS);
      expire_o = 1'b1;
    end else if (state_q != ST_IDLE && tick_i) begin
      timer_d = timer_q - 8'd1;
      if (state_q == ST_BLAST && timer_q == 8'd1) begin
        state_d = ST_IDLE;
        free_o = 1'b1;
      end
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_P1;
      timer_q <= '0;
      x_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign state_o = state_q;
  assign owner_o = owner_q;
  assign x_o = x_q;
  assign y_o = y_q;
endmodule

// File: rtl/bomb_scheduler.sv
// bomb_scheduler: arbitrates bomb placement, runs the slot pool and serializes detonation events
module bomb_scheduler
  import bomb_scheduler_pkg::*;
#(
  parameter int NUM_BOMBS = 6,
  parameter int MAX_PER_PLAYER = 3,
  parameter int FUSE_TICKS = FUSE_TICKS_DEF,
  parameter int BLAST_TICKS = BLAST_TICKS_DEF,
  parameter int COORD_W = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 tick,
  input  logic                 game_reset,
  input  logic                 p1_place,
  input  logic                 p2_place,
  input  logic [COORD_W-1:0]   p1_x,
  input  logic [COORD_W-1:0]   p1_y,
  input  logic [COORD_W-1:0]   p2_x,
  input  logic [COORD_W-1:0]   p2_y,
  input  logic [NUM_BOMBS-1:0] chain_det,
  output logic                 p1_grant,
  output logic                 p2_grant,
  output logic                 p1_deny,
  output logic                 p2_deny,
  input  logic [ID_W-1:0]      rd_id,
  output logic [1:0]           rd_state,
  output logic [COORD_W-1:0]   rd_x,
  output logic [COORD_W-1:0]   rd_y,
  output logic                 rd_owner,
  output logic                 det_valid,
  output logic [ID_W-1:0]      det_id,
  output logic [COORD_W-1:0]   det_x,
  output logic [COORD_W-1:0]   det_y,
  output logic [1:0]           p1_live,
  output logic [1:0]           p2_live
);
  slot_state_e slot_state [NUM_BOMBS];
  owner_e slot_owner [NUM_BOMBS];
  logic [COORD_W-1:0] slot_x [NUM_BOMBS];
  logic [COORD_W-1:0] slot_y [NUM_BOMBS];
  logic [NUM_BOMBS-1:0] load, expire, free, det_q, det_d, det_sel;
  logic [1:0] pend_q, pend_d, req, sel, grant_q, grant_d, deny_q, deny_d;
  logic [1:0][COORD_W-1:0] px_q, px_d, py_q, py_d, rx, ry;
  logic [1:0][1:0] live_q, live_d;
  logic rr_q, rr_d, win, has_idle, dup, ok;
  logic [ID_W-1:0] idle_id;
  for (genvar i = 0; i < NUM_BOMBS; i++) begin : g_slot
    bomb_slot #(.FUSE_TICKS(FUSE_TICKS), .BLAST_TICKS(BLAST_TICKS), .COORD_W(COORD_W)) u_slot (
      .clock    (clock),
      .resetn   (resetn),
      .clear_i  (game_reset),
      .load_i   (load[i]),
      .tick_i   (tick),
      .force_i  (chain_det[i]),
      .owner_i  (owner_e'(win)),
      .x_i      (rx[win]),
      .y_i      (ry[win]),
      .state_o  (slot_state[i]),
      .owner_o  (slot_owner[i]),
      .x_o      (slot_x[i]),
      .y_o      (slot_y[i]),
      .expire_o (expire[i]),
      .free_o   (free[i])
    );
  end
  // a same-cycle place pulse is serviced immediately, with its fresh coordinates
  always_comb begin
    rx[0] = p1_place ? p1_x : px_q[0];
    ry[0] = p1_place ? p1_y : py_q[0];
    rx[1] = p2_place ? p2_x : px_q[1];
    ry[1] = p2_place ? p2_y : py_q[1];
    req = pend_q | {p2_place, p1_place};
    win = &req ? rr_q : req[1];
    sel = |req ? 2'b01 << win : 2'b00;
    has_idle = 1'b0;
    idle_id = '0;
    dup = 1'b0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--) begin
      if (slot_state[i] == ST_IDLE) begin
        has_idle = 1'b1;
        idle_id = ID_W'(i);
      end
      if (slot_state[i] == ST_FUSE && slot_x[i] == rx[win] && slot_y[i] == ry[win]) dup = 1'b1;
    end
    ok = |req && has_idle && !dup && live_q[win] != 2'(MAX_PER_PLAYER) && !game_reset;
    load = ok ? NUM_BOMBS'(1) << idle_id : '0;
    grant_d = ok ? sel : 2'b00;
    deny_d = (ok || game_reset) ? 2'b00 : sel;
    pend_d = game_reset ? 2'b00 : req & ~sel;
    px_d = game_reset ? '0 : rx;
    py_d = game_reset ? '0 : ry;
    rr_d = game_reset ? 1'b0 : rr_q ^ (&req);
  end
  always_comb begin
    int n;
    n = 0;
    live_d = '0;
    for (int p = 0; p < 2; p++) begin
      n = int'(live_q[p]) + int'(grant_d[p]);
      for (int i = 0; i < NUM_BOMBS; i++)
        if (free[i] && slot_owner[i] == owner_e'(p)) n = n - 1;
      live_d[p] = game_reset ? 2'd0 : 2'(n < 0 ? 0 : (n > 3 ? 3 : n));
    end
  end
  always_comb begin
    det_sel = '0;
    det_id = '0;
    det_x = '0;
    det_y = '0;
    rd_state = '0;
    rd_x = '0;
    rd_y = '0;
    rd_owner = 1'b0;
    for (int i = NUM_BOMBS - 1; i >= 0; i--)
      if (det_q[i]) begin
        det_sel = NUM_BOMBS'(1) << i;
        det_id = ID_W'(i);
        det_x = slot_x[i];
        det_y = slot_y[i];
      end
    for (int i = 0; i < NUM_BOMBS; i++)
      if (rd_id == ID_W'(i)) begin
        rd_state = slot_state[i];
        rd_x = slot_x[i];
        rd_y = slot_y[i];
        rd_owner = slot_owner[i];
      end
    det_d = game_reset ? '0 : (det_q & ~det_sel) | expire;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_q <= '0;
      px_q <= '0;
      py_q <= '0;
      rr_q <= 1'b0;
      grant_q <= '0;
      deny_q <= '0;
      det_q <= '0;
      live_q <= '0;
    end else begin
      pend_q <= pend_d;
      px_q <= px_d;
      py_q <= py_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      deny_q <= deny_d;
      det_q <= det_d;
      live_q <= live_d;
    end
  end
  assign det_valid = |det_q;
  assign p1_grant = grant_q[0];
  assign p2_grant = grant_q[1];
  assign p1_deny = deny_q[0];
  assign p2_deny = deny_q[1];
  assign p1_live = live_q[0];
  assign p2_live = live_q[1];
endmodule
